uart_io_tx: RTL and testbench

UART_IO_TX -- requirements
Module: uart_io_tx

---
 rtl/uart_io_tx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_io_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_tx.sv
// uart_io_tx -- buffered UART transmitter for a CPU I/O port.
//
// Bytes written by the CPU are queued in a small FIFO and serialised on tx
// as 8N1 frames (start bit, 8 data bits LSB first, stop bit). Each bit is
// held for CLKS_PER_BIT clocks. Frames are sent back to back while the FIFO
// holds data.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after
// the data bits (11 bit-times per frame instead of 10).
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (2..65535)
//   FIFO_DEPTH    transmit FIFO entries (power of two, 2..64)
// Ports:
//   clock       single clock, rising edge
//   reset       asynchronous active-high reset
//   wr_en       CPU write strobe (address-qualified IOWrite)
//   wr_data     byte to enqueue
//   tx          serial output, idle high, registered
//   fifo_full   FIFO holds FIFO_DEPTH entries
//   fifo_empty  FIFO holds no entries
//   busy        frame in progress or data queued
//   fifo_count  FIFO occupancy, zero-extended to 7 bits
module uart_io_tx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       busy,
  output logic [6:0] fifo_count
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0] DEPTH_C  = 7'(FIFO_DEPTH);
  localparam logic [15:0] LAST_CYC = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [6:0]    count_reg;

  state_t        state_reg;
  logic [15:0]   cyc_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic       bit_done;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == 7'd0);
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign tx         = tx_reg;

  assign bit_done = (cyc_cnt_reg == LAST_CYC);
  // A write into a full FIFO is dropped even if a pop frees a slot on the
  // same edge: acceptance is decided on the occupancy before the edge.
  assign push     = wr_en && !fifo_full;
  // Pop from IDLE, or on the final stop-bit cycle so frames run back to back.
  assign pop      = !fifo_empty &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));
  // Asynchronous read so the head is loaded on the same edge the FSM pops;
  // this keeps write-to-start-bit latency at one edge.
  assign head     = fifo_mem[rd_ptr_reg];

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 7'd1;
        2'b01:   count_reg <= count_reg - 7'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame FSM. tx is updated on the edge that enters each bit so the line is
  // fully registered and never sees wr_en combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cyc_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          cyc_cnt_reg <= '0;
          bit_idx_reg <= '0;
          tx_reg      <= 1'b1;
          if (pop) begin
            shift_reg <= head;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^head;
`endif
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end

        START: begin
          if (bit_done) begin
            cyc_cnt_reg <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            state_reg   <= DATA;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            cyc_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            cyc_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            state_reg   <= STOP;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            cyc_cnt_reg <= '0;
            bit_idx_reg <= '0;
            if (pop) begin
              shift_reg <= head;
`ifdef UART_TX_PARITY_EN
              parity_reg <= ^head;
`endif
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end

        default: begin
          cyc_cnt_reg <= '0;
          tx_reg      <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_tx.sv
// tb_uart_io_tx -- directed bench for uart_io_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Single frames come from a table of {byte, expected line bits}; multi-frame
// and reset corner cases are hand-written sequences. Define UART_TX_PARITY_EN
// to exercise the parity build.
module tb_uart_io_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx;
  logic       fifo_full;
  logic       fifo_empty;
  logic       busy;
  logic [6:0] fifo_count;

  always #5 clock = ~clock;

  uart_io_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .tx        (tx),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Line bits of one frame: bit0 = start, bits 8:1 = data, then parity/stop.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] exp_bits;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wr_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Waits (bounded) for a start bit, samples each bit one cycle into it and
  // returns on the last cycle of the stop bit.
  task automatic capture(output logic [10:0] bits, output int waited);
    bits   = '0;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (tx !== 1'b0 && waited < 300);
    if (tx !== 1'b0) begin
      bits = 11'h7FF;
      return;
    end
    @(negedge clock);
    bits[0] = tx;
    for (int k = 1; k < NB; k++) begin
      repeat (CPB) @(negedge clock);
      bits[k] = tx;
    end
    repeat (CPB / 2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] bits;
    int          waited;
    int          peak;
    int          lows;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[2] = '{8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h01, 11'b1_1_00000001_0};
    vecs[5] = '{8'h80, 11'b1_1_10000000_0};
    vecs[6] = '{8'h07, 11'b1_1_00000111_0};
    vecs[7] = '{8'h03, 11'b1_0_00000011_0};
`else
    vecs[0] = '{8'h55, 11'b0_1_01010101_0};
    vecs[1] = '{8'hA5, 11'b0_1_10100101_0};
    vecs[2] = '{8'h00, 11'b0_1_00000000_0};
    vecs[3] = '{8'hFF, 11'b0_1_11111111_0};
    vecs[4] = '{8'h01, 11'b0_1_00000001_0};
    vecs[5] = '{8'h80, 11'b0_1_10000000_0};
    vecs[6] = '{8'h07, 11'b0_1_00000111_0};
    vecs[7] = '{8'h03, 11'b0_1_00000011_0};
`endif

    // Reset state, before any clock edge (asynchronous reset).
    #1 reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_busy", 32'(busy), 0);
    $display("reset: tx=%0b count=%0d empty=%0b full=%0b busy=%0b",
             tx, fifo_count, fifo_empty, fifo_full, busy);

    // Single frames from the table; each write lands on the first edge
    // after reset release.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wr_en   = 1'b1;
      wr_data = vecs[i].data;
      @(negedge clock);
      wr_en = 1'b0;
      check("tx_high_before_pop", 32'(tx), 1);
      check("count_after_write", 32'(fifo_count), 1);
      check("busy_after_write", 32'(busy), 1);
      capture(bits, waited);
      check("start_latency", 32'(waited), 1);
      check("frame_bits", 32'(bits), 32'(vecs[i].exp_bits));
      check("busy_last_stop_cycle", 32'(busy), 1);
      @(negedge clock);
      check("busy_after_frame", 32'(busy), 0);
      check("tx_idle_after_frame", 32'(tx), 1);
      $display("vec %0d: data=0x%02h line=%b required=%b", i, vecs[i].data, bits, vecs[i].exp_bits);
    end

    // Three writes on consecutive edges: back-to-back frames, peak count 2.
    do_reset();
    peak = 0;
    fork
      begin
        wr_en = 1'b1; wr_data = 8'h01;
        @(negedge clock);
        check("b2b_count_e0", 32'(fifo_count), 1);
        wr_data = 8'h02;
        @(negedge clock);
        check("b2b_count_e1", 32'(fifo_count), 1);
        wr_data = 8'h03;
        @(negedge clock);
        wr_en = 1'b0;
        check("b2b_count_e2", 32'(fifo_count), 2);
        for (int c = 0; c < 120; c++) begin
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
          @(negedge clock);
        end
      end
      begin
        for (int f = 0; f < 3; f++) begin
          capture(bits, waited);
          check("b2b_gap", 32'(waited), (f == 0) ? 2 : 1);
          check("b2b_data", 32'(bits[8:1]), 32'(f + 1));
          check("b2b_stop", 32'(bits[NB-1]), 1);
          $display("b2b frame %0d: data=0x%02h wait=%0d", f, bits[8:1], waited);
        end
        check("b2b_busy_cycle_119", 32'(busy), 1);
        @(negedge clock);
        check("b2b_busy_cycle_120", 32'(busy), 0);
      end
    join
    check("b2b_peak_count", 32'(peak), 2);

    // Ten writes while the first frame is in flight: tenth is dropped.
    do_reset();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wr_en   = 1'b1;
          wr_data = 8'h10 + 8'(i);
          @(negedge clock);
          if (i == 7) begin
            check("fill_count_7", 32'(fifo_count), 7);
            check("fill_not_full", 32'(fifo_full), 0);
          end
          if (i >= 8) begin
            check("fill_count_8", 32'(fifo_count), 8);
            check("fill_full", 32'(fifo_full), 1);
          end
        end
        wr_en = 1'b0;
      end
      begin
        for (int f = 0; f < 9; f++) begin
          capture(bits, waited);
          check("fill_data", 32'(bits[8:1]), 32'(8'h10 + 8'(f)));
          $display("fill frame %0d: data=0x%02h", f, bits[8:1]);
        end
        @(negedge clock);
        check("fill_idle_busy", 32'(busy), 0);
        check("fill_idle_empty", 32'(fifo_empty), 1);
        lows = 0;
        for (int c = 0; c < 60; c++) begin
          @(negedge clock);
          if (tx !== 1'b1) lows++;
        end
        check("fill_no_tenth_frame", 32'(lows), 0);
      end
    join

    // Write at count DEPTH-1 on the same edge as a pop.
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          wr_en   = 1'b1;
          wr_data = 8'h20 + 8'(i);
          @(negedge clock);
        end
        wr_en = 1'b0;
        check("edge_count_pre", 32'(fifo_count), 7);
        repeat (FRAME - 7) @(negedge clock);
        check("edge_count_last_stop", 32'(fifo_count), 7);
        check("edge_tx_stop", 32'(tx), 1);
        wr_en   = 1'b1;
        wr_data = 8'h28;
        @(negedge clock);
        wr_en = 1'b0;
        check("edge_count_after", 32'(fifo_count), 7);
        check("edge_tx_next_start", 32'(tx), 0);
      end
      begin
        for (int f = 0; f < 9; f++) begin
          capture(bits, waited);
          check("edge_data", 32'(bits[8:1]), 32'(8'h20 + 8'(f)));
          if (f > 0) check("edge_gap", 32'(waited), 1);
          $display("edge frame %0d: data=0x%02h", f, bits[8:1]);
        end
      end
    join

    // Reset in cycle 15 of a 0xA5 frame with three bytes queued.
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clock); wr_data = 8'h01;
    @(negedge clock); wr_data = 8'h02;
    @(negedge clock); wr_data = 8'h03;
    @(negedge clock); wr_en = 1'b0;
    check("abort_queued", 32'(fifo_count), 3);
    repeat (13) @(negedge clock);
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_tx", 32'(tx), 1);
    check("abort_count", 32'(fifo_count), 0);
    check("abort_empty", 32'(fifo_empty), 1);
    check("abort_full", 32'(fifo_full), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("abort_no_more_frames", 32'(lows), 0);
    $display("abort: count=%0d tx=%0b busy=%0b", fifo_count, tx, busy);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
